// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with prescaler, load, clear, boundary flags and wrap pulse.
// Define UDC_SAT_EN to build the saturating variant (holds at the bounds, wrap_pulse tied low).
module updown_counter_n #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             step,
    output logic             wrap_pulse
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

`ifdef UDC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [WIDTH-1:0] count_q, count_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic [WIDTH:0]   nxt;

    // Returns {wrapped, next_count} for one count step in direction dir.
    function automatic logic [WIDTH:0] next_count(input logic [WIDTH-1:0] cur, input logic dir);
        logic [WIDTH:0] r;
        r = {1'b0, cur};
        if (dir) begin
            if (cur != MAX_VAL)
                r = {1'b0, cur + WIDTH'(1)};
            else if (!SAT)
                r = {1'b1, {WIDTH{1'b0}}};
        end else begin
            if (cur != '0)
                r = {1'b0, cur - WIDTH'(1)};
            else if (!SAT)
                r = {1'b1, MAX_VAL};
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    assign tick = en && (ps_q == PS_LAST);
    assign nxt  = next_count(count_q, up);

    always_comb begin
        count_d = count_q;
        ps_d    = ps_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
            ps_d    = '0;
        end else if (load) begin
            count_d = clamp_load(load_val);
            ps_d    = '0;
        end else if (tick) begin
            ps_d    = '0;
            step_d  = 1'b1;
            count_d = nxt[WIDTH-1:0];
            wrap_d  = nxt[WIDTH];
        end else if (en) begin
            ps_d    = ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ps_q    <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ps_q    <= ps_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count      = count_q;
    assign at_zero    = (count_q == '0);
    assign at_max     = (count_q == MAX_VAL);
    assign step       = step_q;
    assign wrap_pulse = SAT ? 1'b0 : wrap_q;

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: two instances (PRESCALE=1 and 3, WIDTH=4, MAX_VAL=9) on shared inputs.
// Honours UDC_SAT_EN the same way as the design.
module tb_updown_counter_n;

`ifdef UDC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rst, en, up, clr, load;
    logic [3:0] lv;
    logic [3:0] c1, c3;
    logic       z1, x1, s1, w1, z3, x3, s3, w3;

    int vectors = 0;
    int miscompares = 0;

    int m_cnt[2], m_ps[2];
    bit m_step[2], m_wrap[2];
    int pre[2] = '{1, 3};

    typedef struct {
        bit en, up, clr, load;
        int lv, cnt;
        bit stp, wrp;
    } vec_t;
    vec_t tbl[$];

    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv),
        .count(c1), .at_zero(z1), .at_max(x1), .step(s1), .wrap_pulse(w1));

    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(3)) u_p3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv),
        .count(c3), .at_zero(z3), .at_max(x3), .step(s3), .wrap_pulse(w3));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ps[i] = 0; m_step[i] = 0; m_wrap[i] = 0;
        end
    endtask

    // Reference: count enabled edges; every pre-th one moves the count modulo MAXV+1.
    task automatic model_edge();
        int nxt;
        for (int i = 0; i < 2; i++) begin
            m_step[i] = 0;
            m_wrap[i] = 0;
            if (!rst) begin
                m_cnt[i] = 0; m_ps[i] = 0;
            end else if (clr) begin
                m_cnt[i] = 0; m_ps[i] = 0;
            end else if (load) begin
                m_cnt[i] = (int'(lv) > MAXV) ? MAXV : int'(lv);
                m_ps[i]  = 0;
            end else if (en) begin
                m_ps[i] = m_ps[i] + 1;
                if (m_ps[i] == pre[i]) begin
                    m_ps[i]   = 0;
                    m_step[i] = 1;
                    nxt = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                    if (nxt < 0 || nxt > MAXV) begin
                        if (!SAT) begin
                            m_cnt[i]  = (nxt + MAXV + 1) % (MAXV + 1);
                            m_wrap[i] = 1;
                        end
                    end else begin
                        m_cnt[i] = nxt;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("p1_count", c1, m_cnt[0]);
        chk("p1_step",  s1, m_step[0]);
        chk("p1_wrap",  w1, m_wrap[0]);
        chk("p1_zero",  z1, m_cnt[0] == 0);
        chk("p1_max",   x1, m_cnt[0] == MAXV);
        chk("p3_count", c3, m_cnt[1]);
        chk("p3_step",  s3, m_step[1]);
        chk("p3_wrap",  w3, m_wrap[1]);
        chk("p3_zero",  z3, m_cnt[1] == 0);
        chk("p3_max",   x3, m_cnt[1] == MAXV);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit e, input bit u, input bit c, input bit l, input int v);
        en = e; up = u; clr = c; load = l; lv = 4'(v);
    endtask

    // Called #1 after an edge: pulses rst low between edges and checks the immediate effect.
    task automatic async_reset();
        #3 rst = 1'b0;
        model_reset();
        #1;
        chk("arst_p1_count", c1, 0);
        chk("arst_p3_count", c3, 0);
        chk("arst_p3_zero",  z3, 1);
        chk("arst_p3_step",  s3, 0);
        rst = 1'b1;
    endtask

    task automatic addv(input bit e, input bit u, input bit c, input bit l, input int v,
                        input int cnt, input bit stp, input bit wrp);
        vec_t r;
        r.en = e; r.up = u; r.clr = c; r.load = l; r.lv = v;
        r.cnt = cnt; r.stp = stp; r.wrp = wrp;
        tbl.push_back(r);
    endtask

    initial begin
        int exp_c[6];
        bit exp_w[6];
        int exp_s3[5];

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_count", c1, 0);
        chk("rst_zero",  z1, 1);
        chk("rst_max",   x1, 0);
        chk("rst_step",  s1, 0);
        chk("rst_wrap",  w1, 0);
        repeat (2) cyc();
        rst = 1'b1;

        // PRESCALE=1 vectors starting from count 0 right after reset release.
`ifdef UDC_SAT_EN
        for (int k = 1; k <= 12; k++) addv(1, 1, 0, 0, 0, (k > 9) ? 9 : k, 1, 0);
        addv(1, 0, 0, 0, 0, 8, 1, 0);
        addv(1, 0, 0, 0, 0, 7, 1, 0);
        addv(1, 0, 0, 0, 0, 6, 1, 0);
        addv(1, 0, 0, 0, 0, 5, 1, 0);
        addv(1, 1, 0, 0, 0, 6, 1, 0);
        addv(1, 1, 0, 0, 0, 7, 1, 0);
`else
        for (int k = 1; k <= 12; k++) addv(1, 1, 0, 0, 0, k % 10, 1, k == 10);
        addv(1, 0, 0, 0, 0, 1, 1, 0);
        addv(1, 0, 0, 0, 0, 0, 1, 0);
        addv(1, 0, 0, 0, 0, 9, 1, 1);
        addv(1, 0, 0, 0, 0, 8, 1, 0);
        addv(1, 1, 0, 0, 0, 9, 1, 0);
        addv(1, 1, 0, 0, 0, 0, 1, 1);
`endif
        addv(1, 1, 0, 1, 15, 9, 0, 0);
        addv(1, 1, 1, 1, 5,  0, 0, 0);
        addv(0, 1, 0, 0, 0,  0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].load, tbl[i].lv);
            cyc();
            chk("tbl_count", c1, tbl[i].cnt);
            chk("tbl_step",  s1, tbl[i].stp);
            chk("tbl_wrap",  w1, tbl[i].wrp);
            chk("tbl_max",   x1, tbl[i].cnt == MAXV);
        end

        // Prescaler with an en gap: first step on the 3rd enabled (5th) edge.
        drive(0, 1, 1, 0, 0); cyc();
        exp_s3 = '{0, 0, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            drive((k < 2 || k == 4), 1, 0, 0, 0);
            cyc();
            chk("ps_step", s3, exp_s3[k]);
            chk("ps_count", c3, (k == 4) ? 1 : 0);
        end
        drive(1, 1, 0, 0, 0); cyc();
        chk("ps_single", s3, 0);

        // Async reset with count=7, ps=1 on the PRESCALE=3 instance.
        drive(0, 1, 1, 0, 0); cyc();
        drive(1, 1, 0, 0, 0);
        repeat (22) cyc();
        chk("pre_arst_count", c3, 7);
        async_reset();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("post_arst_step", s3, (k == 2) ? 1 : 0);
            chk("post_arst_count", c3, (k == 2) ? 1 : 0);
        end

        // Bound behaviour on the PRESCALE=1 instance.
        exp_c = SAT ? '{9, 9, 9, 0, 0, 0} : '{9, 0, 1, 0, 9, 8};
        exp_w = SAT ? '{0, 0, 0, 0, 0, 0} : '{0, 1, 0, 0, 1, 0};
        drive(0, 1, 0, 1, 8); cyc();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 0); cyc();
            chk("bound_up_count", c1, exp_c[k]);
            chk("bound_up_wrap",  w1, exp_w[k]);
            chk("bound_up_step",  s1, 1);
        end
        drive(0, 0, 0, 1, 1); cyc();
        for (int k = 3; k < 6; k++) begin
            drive(1, 0, 0, 0, 0); cyc();
            chk("bound_dn_count", c1, exp_c[k]);
            chk("bound_dn_wrap",  w1, exp_w[k]);
        end

        // Randomised traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 15));
            cyc();
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/updown_counter_n.md
# updown_counter_n

Parametrised synchronous up/down counter: the generalised successor of the fixed 4-bit up/down counter. It adds configurable width and terminal value, an input prescaler, parallel load, synchronous clear, boundary flags and a wrap pulse. It is the general-purpose counting primitive for timers, address sequencers and event counters in the design.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32
- MAX_VAL, (2**WIDTH)-1, terminal value; legal range 1..(2**WIDTH)-1; count range is 0..MAX_VAL
- PRESCALE, 1, enabled clocks per count step; legal range 1..256
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous active-low reset
- en  input  1  count enable; gates the prescaler and count steps
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value for load
- count  output  WIDTH  current count, registered
- at_zero  output  1  high when count == 0; decoded from the count register
- at_max  output  1  high when count == MAX_VAL; decoded from the count register
- step  output  1  registered; high for one cycle after each count step
- wrap_pulse  output  1  registered; high for one cycle after each wrap

## Operation
- Internal prescaler ps_cnt, width clog2(PRESCALE) with a minimum of 1 bit. tick = en && (ps_cnt == PRESCALE-1).
- With PRESCALE=1, tick = en.
- Per-edge priority: clr > load > tick > hold.
- clr: count←0, ps_cnt←0, step←0, wrap_pulse←0. It acts regardless of en.
- load: count←min(load_val, MAX_VAL), ps_cnt←0, step←0, wrap_pulse←0. It acts regardless of en.
- en=1 and no tick: ps_cnt←ps_cnt+1, count holds, step←0, wrap_pulse←0.
- tick: ps_cnt←0, step←1, and the count updates as follows:
  - up=1 and count<MAX_VAL: count+1.
  - up=1 and count==MAX_VAL: 0, with wrap_pulse←1.
  - up=0 and count>0: count-1.
  - up=0 and count==0: MAX_VAL, with wrap_pulse←1.
- en=0: ps_cnt, count and flags hold; step and wrap_pulse←0.
- A direction change never resets ps_cnt. The next tick uses the up value sampled on that edge.
- All arithmetic is WIDTH bits. Count never leaves 0..MAX_VAL.

## Timing
- Reset values (asynchronous, immediate on rst low):
  - count=0, ps_cnt=0, step=0, wrap_pulse=0.
  - at_zero=1, at_max=0.
- Reset release: the first edge with rst high may act on inputs.
- Asserting rst mid-count aborts the prescale phase; no partial state survives.
- Latency: 1 clock from sampled inputs to count, step and wrap_pulse.
- at_zero and at_max follow count in the same cycle.
- Step spacing: the first step comes on the PRESCALE-th consecutive enabled edge after reset, clr or load. Later steps come every PRESCALE enabled edges.
- Gaps with en=0 stretch step spacing but do not lose prescaler progress.
- step and wrap_pulse are single-cycle. With PRESCALE=1 and en held high, step stays high continuously.

## Configuration
- UDC_SAT_EN defined: saturating mode.
  - On a tick at a bound in the counting direction (up at MAX_VAL, down at 0), count holds, wrap_pulse stays 0 and step still pulses.
  - wrap_pulse is constant 0.
- UDC_SAT_EN undefined: wrapping mode as described in Operation.

## Test plan
- Reset/basic (WIDTH=4, MAX_VAL=9, PRESCALE=1): rst low, then release; en=1, up=1 for 12 clocks.
  - Required: count 0,1,…,9,0,1,2.
  - wrap_pulse high exactly in the cycle count shows 0 after 9.
  - at_max high while count=9.
- Down wrap and direction change: from count=2, up=0 for 4 clocks, then up=1 for 2 clocks.
  - Required: 1,0,9,8,9,0.
  - wrap_pulse pulses twice, after 0→9 and after 9→0.
- Prescaler (PRESCALE=3): en=1, up=1 from 0, with en dropped for 2 clocks after the 2nd enabled edge.
  - Required: first step occurs on the 3rd enabled edge (5th clock edge), count=1.
  - step stays a single-cycle pulse.
- Priority and clamp: load=1 with load_val=15 and en=1.
  - Required: count=9 (clamped), ps_cnt cleared, no step.
  - Next edge with clr=1 and load=1: count=0.
- Async reset mid-operation: with count=7 and ps_cnt=1, pulse rst low between edges.
  - Required: count=0 and at_zero=1 immediately, before the next clock edge.
  - Counting resumes with a full prescale period.
- UDC_SAT_EN build: up=1 from count=8 for 3 clocks.
  - Required: count 9,9,9 and wrap_pulse always 0.
  - Then up=0 from count=1 for 3 clocks: count 0,0,0.
